fetch_sequencer: RTL

- Instruction-fetch controller that sequences the single-cycle RV32I core.
- Issues in-order requests to instruction memory using a request/grant handshake, then receives the responses.
- Buffers fetched words in a small FIFO and presents them to the core with a valid/ready handshake.
- Applies PC redirects from the core (JAL and branches) and discards stale in-flight responses.

---
 rtl/fetch_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: credit-limited in-order imem requests, response FIFO, PC redirects.
// Build option FETCH_MISALIGN_TRAP_EN adds FETCH_FAULT and a trap state for unaligned redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        FETCH_FAULT
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = 4;
    localparam int unsigned SumW = CntW + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [SumW-1:0] Credits = SumW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StBoot,
        StRun
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        StFault
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CntW-1:0]   out_cnt_q, out_cnt_d;
    logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]       data_q [FIFO_DEPTH];
    logic [31:0]       pc_q   [FIFO_DEPTH];

    logic [SumW-1:0]   credit_sum;
    logic              req;
    logic              grant;
    logic              fifo_valid;
    logic              pop;
    logic              drop_resp;
    logic              live_resp;
    logic              push;
    logic [31:0]       redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              fault_valid_q, fault_valid_d;
    logic [31:0]       fault_pc_q, fault_pc_d;
    logic              fault_pop;
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Stale (dropped) and buffered fetches share the credit pool, so the FIFO can never overflow.
    assign credit_sum = {1'b0, out_cnt_q} + {1'b0, drop_cnt_q} + {1'b0, fifo_cnt_q};
    assign req        = (state_q == StRun) && (credit_sum < Credits);
    assign grant      = req && IMEM_GNT;
    assign fifo_valid = (fifo_cnt_q != '0);
    assign pop        = fifo_valid && INST_READY;
    assign drop_resp  = IMEM_RVALID && (drop_cnt_q != '0);
    assign live_resp  = IMEM_RVALID && (drop_cnt_q == '0);
    assign push       = live_resp && !REDIRECT;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = {REDIRECT_PC[31:2], 2'b00};
    assign fault_pop       = (state_q == StFault) && fault_valid_q && INST_READY;
`else
    assign redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_cnt_d  = out_cnt_q + CntW'(grant) - CntW'(live_resp);
        drop_cnt_d = drop_cnt_q - CntW'(drop_resp);
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_valid_d = fault_pop ? 1'b0 : fault_valid_q;
        fault_pc_d    = fault_pc_q;
`endif

        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)  resp_pc_d  = resp_pc_q + 32'd4;
        if (state_q == StBoot) state_d = StRun;

        if (REDIRECT) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            out_cnt_d  = '0;
            // Every live or just-granted fetch becomes stale; a response this cycle retires one.
            drop_cnt_d = drop_cnt_q + out_cnt_q + CntW'(grant) - CntW'(IMEM_RVALID);
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (REDIRECT_PC[1:0] != 2'b00) begin
                state_d       = StFault;
                fault_valid_d = 1'b1;
                fault_pc_d    = REDIRECT_PC;
            end else begin
                state_d       = StRun;
                fault_valid_d = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        IMEM_REQ   = req;
        IMEM_ADDR  = fetch_pc_q;
        INST       = data_q[rd_ptr_q];
        INST_PC    = pc_q[rd_ptr_q];
        INST_VALID = fifo_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        FETCH_FAULT = 1'b0;
        if (state_q == StFault) begin
            INST        = 32'h0000_0013;
            INST_PC     = fault_pc_q;
            INST_VALID  = fault_valid_q;
            FETCH_FAULT = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= RESET_PC;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= IMEM_RDATA;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fault_valid_q <= 1'b0;
            fault_pc_q    <= RESET_PC;
        end else begin
            fault_valid_q <= fault_valid_d;
            fault_pc_q    <= fault_pc_d;
        end
    end
`endif

endmodule
